regalu_sequencer: RTL and testbench
===================================

# regalu_sequencer

Multi-cycle controller that sequences the register-file/ALU datapath: it accepts one three-address instruction (op, RA, RB, RW) over a valid/ready handshake, then walks it through the read, execute and writeback phases. It drives the register file's address, write-enable and write-data ports and the ALU's operands and select. It sits between an instruction source (test driver or future fetch unit) and the existing RegisterFile and ALU instances. It replaces the ad-hoc double-instantiation of the register file with a single, correctly ordered read-then-write schedule.

## Interface
- AW, 5, register address width
- DW, 32, data width
- SW, 3, ALU select width
- RCW, 16, retired-instruction counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr_op  in  SW  ALU select
- instr_ra, instr_rb  in  AW  source addresses
- instr_rw  in  AW  destination address
- rf_ra, rf_rb  out  AW  register-file read addresses
- rf_rw  out  AW  register-file write address
- rf_we  out  1  register-file write enable
- rf_wd  out  DW  register-file write data
- rf_a, rf_b  in  DW  register-file read data, valid the cycle after rf_ra/rf_rb are presented
- alu_a, alu_b  out  DW  ALU operands
- alu_s  out  SW  ALU select
- alu_y  in  DW  ALU result (combinational from alu_a/alu_b/alu_s)
- done  out  1  one-cycle pulse in the writeback cycle
- retired  out  RCW  count of completed writebacks

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE: instr_ready=1. If instr_valid at the edge, latch op/ra/rb/rw into the instruction register and go to READ. Otherwise stay in IDLE.
- READ: rf_ra/rf_rb driven from the latched ra/rb. At the edge, capture rf_a/rf_b into opa/opb and go to EXEC.
- EXEC: alu_a=opa, alu_b=opb, alu_s=latched op. At the edge, capture alu_y into res and go to WRITE.
- WRITE: rf_we=1, rf_rw=latched rw, rf_wd=res, done=1. At the edge, retired increments (wraps modulo 2^RCW) and the FSM returns to IDLE.
- instr_ready is 0 in READ, EXEC and WRITE. An instruction offered then is not accepted and must be held by the source.
- rf_we is 1 only in WRITE.
- Register outputs (rf_ra/rf_rb/rf_rw/rf_wd/alu_a/alu_b/alu_s) hold their last values outside the states that use them.
- Source equals destination (ra==rw or rb==rw): the operand is read before the write, so the old value is used.
- Back-to-back instructions: the next READ observes the previous WRITE, so there is no hazard.

## Timing
- Accept at edge N. READ spans N..N+1, EXEC spans N+1..N+2, WRITE spans N+2..N+3; the register file is written at edge N+3.
- instr_ready returns to 1 in the cycle after edge N+3.
- Throughput: one instruction per 4 cycles.
- Reset values: state IDLE, instr_ready=1 in the first cycle after reset, rf_we=0, done=0, retired=0. All address, operand, select and data outputs are 0.
- Reset in any state (including WRITE): the in-flight instruction is discarded, no write occurs, and retired is not incremented. rst has priority over instr_valid.

## Configuration
- REGALU_SEQ_R0_PROTECT_EN defined: when latched rw==0, WRITE still pulses done and increments retired, but rf_we stays 0. Register 0 therefore reads as constant.
- REGALU_SEQ_R0_PROTECT_EN undefined: register 0 is writable like any other register.

## Structure
- Shared package regalu_seq_pkg: state enum (IDLE/READ/EXEC/WRITE, 2-bit encoding) and default widths AW/DW/SW/RCW as constants.
- ALU op encodings stay with the ALU's existing definitions and are not duplicated here.
- The block is a single flat module with no sub-module. The FSM, instruction register, operand/result registers and counter together are too small to justify splitting.

## Test plan
- After reset, write r1=5, r2=3 by preload. Issue op=add, ra=1, rb=2, rw=3 -> rf_we high exactly one cycle at accept+3 with rf_rw=3, rf_wd=8; done pulses once; retired=1.
- Hold instr_valid high with two instructions -> the second is accepted exactly 4 cycles after the first; instr_ready is low for 3 cycles between acceptances.
- ra=rw=4 (r4=10), rb=5 (r5=1), op=sub -> r4 becomes 9, and a subsequent read of r4 in READ returns 9.
- Assert rst in EXEC -> rf_we never rises, done stays 0, retired stays 0, and instr_ready=1 in the cycle after reset.
- rw=0 with macro defined -> done=1, rf_we=0, r0 unchanged. Without the macro -> rf_we=1 and r0 is written.
- Preset retired=2^RCW-1 (or issue enough instructions to reach it), then complete one more -> retired wraps to 0.

Source files
------------

// File: rtl/regalu_seq_pkg.sv
// Shared types and default widths for the register-file/ALU sequencer.
package regalu_seq_pkg;

    localparam int AW_DEFAULT  = 5;
    localparam int DW_DEFAULT  = 32;
    localparam int SW_DEFAULT  = 3;
    localparam int RCW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/regalu_sequencer.sv
// Four-phase (accept/read/execute/writeback) sequencer for the register file and ALU.
// Optional build macro: REGALU_SEQ_R0_PROTECT_EN keeps register 0 from being written.
module regalu_sequencer
    import regalu_seq_pkg::*;
#(
    parameter int AW  = AW_DEFAULT,
    parameter int DW  = DW_DEFAULT,
    parameter int SW  = SW_DEFAULT,
    parameter int RCW = RCW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [SW-1:0]  instr_op,
    input  logic [AW-1:0]  instr_ra,
    input  logic [AW-1:0]  instr_rb,
    input  logic [AW-1:0]  instr_rw,
    output logic [AW-1:0]  rf_ra,
    output logic [AW-1:0]  rf_rb,
    output logic [AW-1:0]  rf_rw,
    output logic           rf_we,
    output logic [DW-1:0]  rf_wd,
    input  logic [DW-1:0]  rf_a,
    input  logic [DW-1:0]  rf_b,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [SW-1:0]  alu_s,
    input  logic [DW-1:0]  alu_y,
    output logic           done,
    output logic [RCW-1:0] retired
);

    state_t         state;
    state_t         state_next;
    logic [SW-1:0]  ir_op;
    logic [AW-1:0]  ir_ra;
    logic [AW-1:0]  ir_rb;
    logic [AW-1:0]  ir_rw;
    logic [DW-1:0]  opa;
    logic [DW-1:0]  opb;
    logic [DW-1:0]  res;
    logic [RCW-1:0] retired_cnt;
    logic           wb_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (instr_valid) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers hold their contents outside the phase that loads them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_op       <= '0;
            ir_ra       <= '0;
            ir_rb       <= '0;
            ir_rw       <= '0;
            opa         <= '0;
            opb         <= '0;
            res         <= '0;
            retired_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir_op <= instr_op;
                        ir_ra <= instr_ra;
                        ir_rb <= instr_rb;
                        ir_rw <= instr_rw;
                    end
                end
                READ: begin
                    opa <= rf_a;
                    opb <= rf_b;
                end
                EXEC:    res <= alu_y;
                WRITE:   retired_cnt <= retired_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Writeback strobes are masked by rst so a reset landing in WRITE never commits.
    always_comb begin
        instr_ready = (state == IDLE);
        wb_active   = (state == WRITE) && !rst;
        done        = wb_active;
`ifdef REGALU_SEQ_R0_PROTECT_EN
        rf_we       = wb_active && (ir_rw != '0);
`else
        rf_we       = wb_active;
`endif
    end

    assign rf_ra   = ir_ra;
    assign rf_rb   = ir_rb;
    assign rf_rw   = ir_rw;
    assign rf_wd   = res;
    assign alu_a   = opa;
    assign alu_b   = opb;
    assign alu_s   = ir_op;
    assign retired = retired_cnt;

endmodule

// File: tb/tb_regalu_sequencer.sv
// Self-checking bench for regalu_sequencer with a behavioural register file, ALU and reference model.
module tb_regalu_sequencer;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int SW  = 3;
    localparam int RCW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           instr_valid;
    logic           instr_ready;
    logic [SW-1:0]  instr_op;
    logic [AW-1:0]  instr_ra, instr_rb, instr_rw;
    logic [AW-1:0]  rf_ra, rf_rb, rf_rw;
    logic           rf_we;
    logic [DW-1:0]  rf_wd, rf_a, rf_b;
    logic [DW-1:0]  alu_a, alu_b, alu_y;
    logic [SW-1:0]  alu_s;
    logic           done;
    logic [RCW-1:0] retired;

    regalu_sequencer #(.AW(AW), .DW(DW), .SW(SW), .RCW(RCW)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rw(instr_rw),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rw(rf_rw), .rf_we(rf_we), .rf_wd(rf_wd),
        .rf_a(rf_a), .rf_b(rf_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .done(done), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [SW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0: alu_f = a + b;
            3'd1: alu_f = a - b;
            3'd2: alu_f = a & b;
            3'd3: alu_f = a | b;
            3'd4: alu_f = a ^ b;
            3'd5: alu_f = a << b[4:0];
            3'd6: alu_f = a >> b[4:0];
            default: alu_f = b;
        endcase
    endfunction

    // Register file and ALU surrounding the sequencer.
    logic [DW-1:0] rf_mem [32];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) rf_mem[pl_addr] <= pl_data;
        else if (rf_we) rf_mem[rf_rw] <= rf_wd;
    end
    assign rf_a  = rf_mem[rf_ra];
    assign rf_b  = rf_mem[rf_rb];
    assign alu_y = alu_f(alu_s, alu_a, alu_b);

    // Event monitor
    int cyc = 0, we_cnt = 0, done_cnt = 0, low_cnt = 0;
    int acc_q[$];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rf_we) we_cnt = we_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
        if (!instr_ready) low_cnt = low_cnt + 1;
        if (instr_valid && instr_ready) acc_q.push_back(cyc);
    end

    // Reference state
    logic [DW-1:0]  model [32];
    logic [RCW-1:0] exp_ret;
    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        model[a] = d;
    endtask

    function automatic logic we_expected(input logic [AW-1:0] rw);
`ifdef REGALU_SEQ_R0_PROTECT_EN
        we_expected = (rw != '0);
`else
        we_expected = 1'b1;
`endif
    endfunction

    task automatic issue(input string name, input logic [SW-1:0] op, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic [AW-1:0] rw, input logic [DW-1:0] exp_res);
        logic [DW-1:0] a, b;
        logic          we;
        int            n;
        a  = model[ra];
        b  = model[rb];
        we = we_expected(rw);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_ra = ra; instr_rb = rb; instr_rw = rw;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            fail_now({name, "_accept"});
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check({name, "_read_ready"}, instr_ready, 0);
        check({name, "_read_ra"}, {rf_ra, rf_rb}, {ra, rb});
        check({name, "_read_we_done"}, {rf_we, done}, 0);
        @(posedge clk); #1;
        check({name, "_exec_ops"}, {alu_a, alu_b}, {a, b});
        check({name, "_exec_sel"}, alu_s, op);
        @(posedge clk); #1;
        check({name, "_wb_we"}, rf_we, we);
        check({name, "_wb_rw"}, rf_rw, rw);
        check({name, "_wb_wd"}, rf_wd, exp_res);
        check({name, "_wb_done_ready"}, {done, instr_ready}, 2'b10);
        @(posedge clk); #1;
        exp_ret = exp_ret + 1'b1;
        if (we) model[rw] = exp_res;
        check({name, "_after_ready_done_we"}, {instr_ready, done, rf_we}, 3'b100);
        check({name, "_retired"}, retired, exp_ret);
        check({name, "_regfile"}, rf_mem[rw], model[rw]);
    endtask

    typedef struct {
        string         name;
        logic [SW-1:0] op;
        logic [AW-1:0] ra, rb, rw;
        logic [DW-1:0] res;
    } vec_t;
    vec_t tbl[9];

    task automatic reset_in(input string name, input int phase_edges, input logic [AW-1:0] rw);
        int snap_we, snap_done;
        logic [DW-1:0] old;
        snap_we = we_cnt; snap_done = done_cnt; old = rf_mem[rw];
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd0; instr_ra = 5'd1; instr_rb = 5'd2; instr_rw = rw;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (phase_edges) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        exp_ret = '0;
        check({name, "_ready_after"}, instr_ready, 1);
        check({name, "_retired"}, retired, 0);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_no_we"}, we_cnt - snap_we, 0);
        check({name, "_no_done"}, done_cnt - snap_done, 0);
        check({name, "_reg_kept"}, rf_mem[rw], old);
    endtask

    initial begin
        int base, lowsnap, n;
        logic [SW-1:0] op;
        logic [AW-1:0] ra, rb, rw;

        tbl[0] = '{"add",   3'd0, 5'd1, 5'd2, 5'd3,  32'd8};
        tbl[1] = '{"sub_rw", 3'd1, 5'd4, 5'd5, 5'd4,  32'd9};
        tbl[2] = '{"sub_rd", 3'd1, 5'd4, 5'd5, 5'd6,  32'd8};
        tbl[3] = '{"and",   3'd2, 5'd1, 5'd2, 5'd7,  32'd1};
        tbl[4] = '{"or",    3'd3, 5'd1, 5'd2, 5'd8,  32'd7};
        tbl[5] = '{"xor",   3'd4, 5'd1, 5'd2, 5'd9,  32'd6};
        tbl[6] = '{"sll",   3'd5, 5'd1, 5'd2, 5'd10, 32'd40};
        tbl[7] = '{"srl",   3'd6, 5'd4, 5'd5, 5'd13, 32'd4};
        tbl[8] = '{"passb", 3'd7, 5'd0, 5'd3, 5'd14, 32'd8};

        rst = 1'b1; instr_valid = 1'b0;
        instr_op = '0; instr_ra = '0; instr_rb = '0; instr_rw = '0;
        exp_ret = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", instr_ready, 1);
        check("rst_we_done", {rf_we, done}, 0);
        check("rst_retired", retired, 0);
        check("rst_addr", {rf_ra, rf_rb, rf_rw}, 0);
        check("rst_data", {rf_wd, alu_a}, 0);
        check("rst_alu_b_s", {alu_b, alu_s}, 0);

        for (int i = 0; i < 32; i++) preload(i[AW-1:0], $urandom);
        preload(5'd0, 32'd0);
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd3);
        preload(5'd4, 32'd10);
        preload(5'd5, 32'd1);

        reset_in("rst_exec", 1, 5'd20);
        reset_in("rst_write", 2, 5'd21);

        for (int i = 0; i < 9; i++)
            issue(tbl[i].name, tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rw, tbl[i].res);

        issue("r0_write", 3'd7, 5'd0, 5'd1, 5'd0, 32'd5);
`ifdef REGALU_SEQ_R0_PROTECT_EN
        check("r0_kept", rf_mem[0], 0);
`else
        check("r0_written", rf_mem[0], 5);
`endif

        // Back-to-back: valid stays high across two instructions.
        base = acc_q.size(); lowsnap = low_cnt;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd0; instr_ra = 5'd1; instr_rb = 5'd2; instr_rw = 5'd11;
        n = 0;
        while (acc_q.size() == base && n < 20) begin @(negedge clk); n++; end
        instr_op = 3'd1; instr_ra = 5'd11; instr_rb = 5'd1; instr_rw = 5'd12;
        n = 0;
        while (acc_q.size() == base + 1 && n < 20) begin @(negedge clk); n++; end
        instr_valid = 1'b0;
        if (acc_q.size() < base + 2) begin
            fail_now("b2b_accept");
        end else begin
            check("b2b_gap", acc_q[base+1] - acc_q[base], 4);
            check("b2b_ready_low", low_cnt - lowsnap, 3);
            repeat (4) @(posedge clk);
            #1;
            exp_ret = exp_ret + 2'd2;
            model[11] = 32'd8;
            model[12] = 32'd3;
            check("b2b_first", rf_mem[11], 8);
            check("b2b_second", rf_mem[12], 3);
            check("b2b_retired", retired, exp_ret);
        end

        for (int i = 0; i < 24; i++) begin
            op = SW'($urandom_range(0, 7));
            ra = AW'($urandom_range(0, 31));
            rb = AW'($urandom_range(0, 31));
            rw = AW'($urandom_range(0, 31));
            issue("rand", op, ra, rb, rw, alu_f(op, model[ra], model[rb]));
        end

        n = 0;
        while (exp_ret != '1 && n < 40) begin
            op = SW'($urandom_range(0, 7));
            ra = AW'($urandom_range(0, 31));
            rb = AW'($urandom_range(0, 31));
            rw = AW'($urandom_range(1, 31));
            issue("fill", op, ra, rb, rw, alu_f(op, model[ra], model[rb]));
            n++;
        end
        issue("wrap", 3'd0, 5'd1, 5'd2, 5'd15, alu_f(3'd0, model[1], model[2]));
        check("retired_wrap", retired, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
